counter_ud_ctrl: RTL and testbench



---
 rtl/counter_ud_pkg.sv | 20 ++
 rtl/counter_ud_ctrl_if.sv | 24 ++
 rtl/counter_ud.sv | 24 ++
 rtl/counter_ud_ctrl.sv | 154 +++++++++++++++
 tb/tb_counter_ud_ctrl.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/counter_ud_pkg.sv
// Shared types and default sizes for the counter_ud controller.
package counter_ud_pkg;

  localparam int WIDTH_DEF  = 4;
  localparam int STEP_W_DEF = 8;

  typedef enum logic [1:0] {
    OP_LOAD = 2'd0,
    OP_UP   = 2'd1,
    OP_DOWN = 2'd2,
    OP_RSVD = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_e;

endpackage

// File: rtl/counter_ud_ctrl_if.sv
// Command handshake and status bus of the counter_ud controller.
interface counter_ud_ctrl_if #(
  parameter int WIDTH  = 4,
  parameter int STEP_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [WIDTH-1:0]  cmd_val;
  logic [STEP_W-1:0] cmd_steps;
  logic              done;
  logic [STEP_W-1:0] wrap_cnt;
  logic              err;

  modport master (
    output cmd_valid, cmd_op, cmd_val, cmd_steps,
    input  cmd_ready, done, wrap_cnt, err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_val, cmd_steps,
    output cmd_ready, done, wrap_cnt, err
  );
endinterface

// File: rtl/counter_ud.sv
// Plain up/down counter with parallel load; rollover flags the all-ones value.
module counter_ud #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] load,
  input  logic             load_en,
  input  logic             down,
  output logic [WIDTH-1:0] count,
  output logic             rollover
);

  // Count register: load has priority over stepping.
  always_ff @(posedge clk) begin
    if (rst)          count <= '0;
    else if (load_en) count <= load;
    else if (down)    count <= count - WIDTH'(1);
    else              count <= count + WIDTH'(1);
  end

  assign rollover = &count;

endmodule

// File: rtl/counter_ud_ctrl.sv
// Command-driven controller for counter_ud: keeps a shadow of the expected
// count, holds the counter by reloading it between commands, counts wraps
// and flags any disagreement between the counter and the shadow.
module counter_ud_ctrl
  import counter_ud_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int STEP_W = STEP_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  counter_ud_ctrl_if.slave  bus,
  output logic [WIDTH-1:0]  ctr_load,
  output logic              ctr_load_en,
  output logic              ctr_down,
  input  logic [WIDTH-1:0]  ctr_count,
  input  logic              ctr_rollover
);

  state_e            state, state_nxt;
  logic [WIDTH-1:0]  shadow, shadow_nxt;
  logic [WIDTH-1:0]  load_q, load_nxt;
  logic              load_en_q, load_en_nxt;
  logic              down_q, down_nxt;
  logic              ready_q, ready_nxt;
  logic              done_q, done_nxt;
  logic [STEP_W-1:0] remain, remain_nxt;
  logic [STEP_W-1:0] wrap_q, wrap_nxt;
  logic              err_q;

  op_e               op;
  logic              accept;
  logic              has_steps;
  logic              last_step;
  logic [WIDTH-1:0]  stepped;
  logic              wraps;
  logic [STEP_W-1:0] wrap_inc;

  assign op        = op_e'(bus.cmd_op);
  assign accept    = bus.cmd_valid && ready_q;   // ready_q is only high in IDLE
  assign has_steps = (op == OP_UP || op == OP_DOWN) && (bus.cmd_steps != '0);
  assign last_step = (remain == STEP_W'(1));
  // The shadow moves the same way the counter does on this edge.
  assign stepped   = down_q ? shadow - WIDTH'(1) : shadow + WIDTH'(1);
  assign wraps     = down_q ? (shadow == '0) : (&shadow);
  assign wrap_inc  = (&wrap_q) ? wrap_q : wrap_q + STEP_W'(1);

  // State and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      shadow    <= '0;
      load_q    <= '0;
      load_en_q <= 1'b1;
      down_q    <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      remain    <= '0;
      wrap_q    <= '0;
    end else begin
      state     <= state_nxt;
      shadow    <= shadow_nxt;
      load_q    <= load_nxt;
      load_en_q <= load_en_nxt;
      down_q    <= down_nxt;
      ready_q   <= ready_nxt;
      done_q    <= done_nxt;
      remain    <= remain_nxt;
      wrap_q    <= wrap_nxt;
    end
  end

  // Next state.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (op == OP_LOAD) state_nxt = S_LOAD;
          else if (has_steps) state_nxt = S_RUN;
        end
      end
      S_LOAD:  state_nxt = S_IDLE;
      S_RUN:   if (last_step) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath.
  always_comb begin
    shadow_nxt  = shadow;
    load_nxt    = load_q;
    load_en_nxt = load_en_q;
    down_nxt    = down_q;
    ready_nxt   = ready_q;
    done_nxt    = 1'b0;
    remain_nxt  = remain;
    wrap_nxt    = wrap_q;
    case (state)
      S_IDLE: begin
        if (accept) begin
          wrap_nxt = '0;
          if (op == OP_LOAD) begin
            load_nxt    = bus.cmd_val;
            load_en_nxt = 1'b1;
            ready_nxt   = 1'b0;
          end else if (has_steps) begin
            load_en_nxt = 1'b0;
            down_nxt    = (op == OP_DOWN);
            remain_nxt  = bus.cmd_steps;
            ready_nxt   = 1'b0;
          end else begin
            // Zero steps or reserved op: complete at once, counter keeps holding.
            done_nxt = 1'b1;
          end
        end
      end
      S_LOAD: begin
        shadow_nxt = load_q;
        done_nxt   = 1'b1;
        ready_nxt  = 1'b1;
      end
      S_RUN: begin
        shadow_nxt = stepped;
        remain_nxt = remain - STEP_W'(1);
        if (wraps) wrap_nxt = wrap_inc;
        if (last_step) begin
          // Return to hold mode, reloading the count just reached.
          load_en_nxt = 1'b1;
          load_nxt    = stepped;
          down_nxt    = 1'b0;
          done_nxt    = 1'b1;
          ready_nxt   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Sticky consistency check of the counter against the shadow.
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else if ((ctr_count != shadow) || (ctr_rollover != (&shadow))) err_q <= 1'b1;
  end

  assign ctr_load     = load_q;
  assign ctr_load_en  = load_en_q;
  assign ctr_down     = down_q;
  assign bus.cmd_ready = ready_q;
  assign bus.done      = done_q;
  assign bus.wrap_cnt  = wrap_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_counter_ud_ctrl.sv
// Bench for counter_ud_ctrl driving a real counter_ud, with a fault mux on count.
module tb_counter_ud_ctrl;

  localparam int W  = 4;
  localparam int SW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  ctr_load;
  logic          ctr_load_en;
  logic          ctr_down;
  logic [W-1:0]  cnt_count;
  logic [W-1:0]  ctr_count;
  logic          ctr_rollover;
  logic          inj = 1'b0;
  logic [W-1:0]  inj_val = '0;

  int errors = 0;
  int checks = 0;
  int mcount = 0;   // model of the counter value between commands
  bit exp_err = 1'b0;

  counter_ud_ctrl_if #(.WIDTH(W), .STEP_W(SW)) bus ();

  counter_ud_ctrl #(.WIDTH(W), .STEP_W(SW)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .ctr_load(ctr_load), .ctr_load_en(ctr_load_en), .ctr_down(ctr_down),
    .ctr_count(ctr_count), .ctr_rollover(ctr_rollover)
  );

  counter_ud #(.WIDTH(W)) u_cnt (
    .clk(clk), .rst(rst), .load(ctr_load), .load_en(ctr_load_en),
    .down(ctr_down), .count(cnt_count), .rollover(ctr_rollover)
  );

  assign ctr_count = inj ? inj_val : cnt_count;

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    logic [3:0] val;
    logic [7:0] steps;
    int         exp_count;
    int         exp_wrap;
    int         exp_lat;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain modular arithmetic over the command rules.
  function automatic int m_final(int op, int c, int val, int steps);
    case (op)
      0: return val;
      1: return (c + steps) % 16;
      2: return (((c - steps) % 16) + 16) % 16;
      default: return c;
    endcase
  endfunction

  function automatic int m_wraps(int op, int c, int steps);
    int w;
    case (op)
      1: w = (c + steps) / 16;
      2: w = (steps + 15 - c) / 16;
      default: w = 0;
    endcase
    return (w > 255) ? 255 : w;
  endfunction

  function automatic int m_lat(int op, int steps);
    if (op == 0) return 1;
    if (op == 3) return 0;
    return steps;
  endfunction

  // Counter value k edges after the accept edge.
  function automatic int m_at(int op, int c, int val, int steps, int k);
    int s;
    s = (k < steps) ? k : steps;
    case (op)
      0: return (k >= 1) ? val : c;
      1: return (c + s) % 16;
      2: return (((c - s) % 16) + 16) % 16;
      default: return c;
    endcase
  endfunction

  task automatic run_cmd(input int op, input int val, input int steps,
                         input int exp_cnt, input int exp_wrap, input int exp_lat);
    bit seen;
    int lat;
    seen = 0;
    lat  = -1;
    @(negedge clk);
    chk("ready_before_cmd", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op[1:0];
    bus.cmd_val   = val[3:0];
    bus.cmd_steps = steps[7:0];
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    for (int k = 0; k <= exp_lat + 4; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      chk("count_trace", ctr_count, m_at(op, mcount, val, steps, k));
      chk("rollover_trace", ctr_rollover, int'(m_at(op, mcount, val, steps, k) == 15));
      chk("err_trace", bus.err, exp_err);
      if (bus.done) begin
        seen = 1;
        lat  = k;
        break;
      end
      chk("ready_busy", bus.cmd_ready, 0);
      if ((op == 1 || op == 2) && steps > 0) chk("load_en_run", ctr_load_en, 0);
    end
    if (!seen) chk("done_timeout", 0, 1);
    chk("done_latency", lat, exp_lat);
    chk("final_count", ctr_count, exp_cnt);
    chk("wrap_cnt", bus.wrap_cnt, exp_wrap);
    chk("hold_load_en", ctr_load_en, 1);
    chk("hold_load", ctr_load, exp_cnt);
    chk("ready_done", bus.cmd_ready, 1);
    mcount = exp_cnt;
    @(posedge clk);
    #1;
    chk("done_one_cycle", bus.done, 0);
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{op: 2'd0, val: 4'hC, steps: 8'd0,  exp_count: 12, exp_wrap: 0, exp_lat: 1};
    vecs[1] = '{op: 2'd1, val: 4'h0, steps: 8'd5,  exp_count: 1,  exp_wrap: 1, exp_lat: 5};
    vecs[2] = '{op: 2'd2, val: 4'h0, steps: 8'd3,  exp_count: 14, exp_wrap: 1, exp_lat: 3};
    vecs[3] = '{op: 2'd1, val: 4'h0, steps: 8'd0,  exp_count: 14, exp_wrap: 0, exp_lat: 0};
    vecs[4] = '{op: 2'd3, val: 4'h5, steps: 8'd7,  exp_count: 14, exp_wrap: 0, exp_lat: 0};
    vecs[5] = '{op: 2'd2, val: 4'h0, steps: 8'd0,  exp_count: 14, exp_wrap: 0, exp_lat: 0};

    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'd0;
    bus.cmd_val   = '0;
    bus.cmd_steps = '0;

    // Reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_load_en", ctr_load_en, 1);
    chk("rst_load", ctr_load, 0);
    chk("rst_ready", bus.cmd_ready, 1);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_wrap", bus.wrap_cnt, 0);
    chk("rst_count", ctr_count, 0);

    // Directed vectors
    for (int i = 0; i < 6; i++)
      run_cmd(vecs[i].op, vecs[i].val, vecs[i].steps,
              vecs[i].exp_count, vecs[i].exp_wrap, vecs[i].exp_lat);

    // Fault injection: one bad count cycle makes err sticky
    @(negedge clk);
    inj_val = 4'h3;
    inj     = 1'b1;
    @(posedge clk);
    #1;
    inj = 1'b0;
    chk("err_after_fault", bus.err, 1);
    exp_err = 1'b1;
    run_cmd(1, 0, 2, 0, 1, 2);
    chk("err_sticky", bus.err, 1);

    // Reset during RUN with cmd_valid held high
    run_cmd(0, 14, 0, 14, 0, 1);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'd1;
    bus.cmd_steps = 8'd10;
    @(posedge clk);
    #1;
    bus.cmd_op  = 2'd0;
    bus.cmd_val = 4'h5;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      chk("abort_ready", bus.cmd_ready, 0);
      chk("abort_count", ctr_count, (14 + k) % 16);
    end
    chk("abort_wrap_pre", bus.wrap_cnt, 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_load", ctr_load, 0);
    chk("abort_load_en", ctr_load_en, 1);
    chk("abort_done", bus.done, 0);
    chk("abort_wrap", bus.wrap_cnt, 0);
    chk("abort_err", bus.err, 0);
    chk("abort_ready_rst", bus.cmd_ready, 1);
    chk("abort_count_rst", ctr_count, 0);
    @(negedge clk);
    rst = 1'b0;
    bus.cmd_valid = 1'b0;
    exp_err = 1'b0;
    mcount  = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk("abort_no_done", bus.done, 0);
      chk("abort_hold", ctr_count, 0);
    end

    // Randomized commands against the model
    for (int i = 0; i < 40; i++) begin
      int op, val, steps;
      op    = int'($urandom_range(0, 3));
      val   = int'($urandom_range(0, 15));
      steps = int'($urandom_range(0, 20));
      run_cmd(op, val, steps, m_final(op, mcount, val, steps),
              m_wraps(op, mcount, steps), m_lat(op, steps));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
